// File: rtl/spi_reg_bridge_if.sv
// Register-bus side of the SPI bridge: address/data strobes out, read
// acknowledge and data back from the register file.
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-2:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              wr_stb;
  logic              rd_stb;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output bus_addr, bus_wdata, wr_stb, rd_stb,
    input  rd_ack, rd_data
  );

  modport slave (
    input  bus_addr, bus_wdata, wr_stb, rd_stb,
    output rd_ack, rd_data
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave, oversampled in sys_clk, turning address/dummy/data frames
// into single-cycle register-bus write strobes and read requests.
module spi_reg_bridge #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int DUMMY_CYCLES = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               spi_clk,
  input  logic               spi_mosi,
  input  logic               spi_cs_n,
  output logic               spi_miso,
  spi_reg_bridge_if.master   bus,
  output logic               frame_err,
  output logic               rd_err
);

  localparam int MAX_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MAX_CNT = (MAX_AD > DUMMY_CYCLES) ? MAX_AD : DUMMY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_DONE
  } state_t;

  // CS synchronizer clears to 0 so a CS already held low when reset
  // releases never looks like a fresh falling edge.
  logic [SYNC_STAGES-1:0] sck_sync_reg, mosi_sync_reg, cs_sync_reg;
  logic                   sck_prev_reg, cs_prev_reg;
  logic                   sck_s, mosi_s, cs_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sck_sync_reg  <= '0;
      mosi_sync_reg <= '0;
      cs_sync_reg   <= '0;
      sck_prev_reg  <= 1'b0;
      cs_prev_reg   <= 1'b0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
      sck_prev_reg  <= sck_sync_reg[SYNC_STAGES-1];
      cs_prev_reg   <= cs_sync_reg[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_reg;
  assign sck_fall = ~sck_s & sck_prev_reg;
  assign cs_rise  = cs_s & ~cs_prev_reg;
  assign cs_fall  = ~cs_s & cs_prev_reg;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [ADDR_W-2:0] addr_sr_reg, addr_sr_next;
  logic [ADDR_W-2:0] bus_addr_reg, bus_addr_next;
  logic              rd_flag_reg, rd_flag_next;
  logic              rd_wait_reg, rd_wait_next;
  logic              first_fall_reg, first_fall_next;
  logic [DATA_W-1:0] tx_reg, tx_next;
  logic [DATA_W-2:0] rx_reg, rx_next;
  logic              miso_reg, miso_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              wr_stb_reg, wr_stb_next;
  logic              rd_stb_reg, rd_stb_next;
  logic              frame_err_reg, frame_err_next;
  logic              rd_err_reg, rd_err_next;

  logic [ADDR_W-1:0] addr_shift;
  logic [DATA_W-1:0] rx_shift;
  logic              in_frame;

  assign addr_shift = {addr_sr_reg, mosi_s};
  assign rx_shift   = {rx_reg, mosi_s};
  assign in_frame   = (state_reg == S_ADDR) || (state_reg == S_DUMMY) ||
                      (state_reg == S_DATA);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_reg      <= S_IDLE;
      bit_cnt_reg    <= '0;
      addr_sr_reg    <= '0;
      bus_addr_reg   <= '0;
      rd_flag_reg    <= 1'b0;
      rd_wait_reg    <= 1'b0;
      first_fall_reg <= 1'b0;
      tx_reg         <= '0;
      rx_reg         <= '0;
      miso_reg       <= 1'b0;
      wdata_reg      <= '0;
      wr_stb_reg     <= 1'b0;
      rd_stb_reg     <= 1'b0;
      frame_err_reg  <= 1'b0;
      rd_err_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      addr_sr_reg    <= addr_sr_next;
      bus_addr_reg   <= bus_addr_next;
      rd_flag_reg    <= rd_flag_next;
      rd_wait_reg    <= rd_wait_next;
      first_fall_reg <= first_fall_next;
      tx_reg         <= tx_next;
      rx_reg         <= rx_next;
      miso_reg       <= miso_next;
      wdata_reg      <= wdata_next;
      wr_stb_reg     <= wr_stb_next;
      rd_stb_reg     <= rd_stb_next;
      frame_err_reg  <= frame_err_next;
      rd_err_reg     <= rd_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    addr_sr_next    = addr_sr_reg;
    bus_addr_next   = bus_addr_reg;
    rd_flag_next    = rd_flag_reg;
    rd_wait_next    = rd_wait_reg;
    first_fall_next = first_fall_reg;
    tx_next         = tx_reg;
    rx_next         = rx_reg;
    miso_next       = miso_reg;
    wdata_next      = wdata_reg;
    wr_stb_next     = 1'b0;
    rd_stb_next     = 1'b0;
    frame_err_next  = 1'b0;
    rd_err_next     = 1'b0;

    if (cs_rise && in_frame) begin
      state_next     = S_IDLE;
      frame_err_next = 1'b1;
      rd_wait_next   = 1'b0;
      miso_next      = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cs_fall) begin
            state_next      = S_ADDR;
            bit_cnt_next    = '0;
            addr_sr_next    = '0;
            rx_next         = '0;
            tx_next         = '0;
            rd_wait_next    = 1'b0;
            first_fall_next = 1'b1;
            miso_next       = 1'b0;
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            addr_sr_next = addr_shift[ADDR_W-2:0];
            if (bit_cnt_reg == ADDR_LAST) begin
              bus_addr_next = addr_shift[ADDR_W-2:0];
              rd_flag_next  = addr_shift[ADDR_W-1];
              rd_stb_next   = addr_shift[ADDR_W-1];
              rd_wait_next  = addr_shift[ADDR_W-1];
              bit_cnt_next  = '0;
              state_next    = S_DUMMY;
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end
        end
        S_DUMMY: begin
          if (rd_wait_reg && bus.rd_ack) begin
            tx_next      = bus.rd_data;
            rd_wait_next = 1'b0;
          end
          if (sck_rise) begin
            if (bit_cnt_reg == DUMMY_LAST) begin
              bit_cnt_next = '0;
              state_next   = S_DATA;
              // Still waiting at the last turnaround rise: give up and send zeros.
              if (rd_wait_reg && !bus.rd_ack) begin
                rd_err_next  = 1'b1;
                rd_wait_next = 1'b0;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (sck_fall) begin
            if (first_fall_reg) begin
              miso_next       = tx_reg[DATA_W-1];
              first_fall_next = 1'b0;
            end else begin
              tx_next   = tx_reg << 1;
              miso_next = tx_reg[DATA_W-2];
            end
          end
          if (sck_rise) begin
            rx_next = rx_shift[DATA_W-2:0];
            if (bit_cnt_reg == DATA_LAST) begin
              state_next  = S_DONE;
              wr_stb_next = ~rd_flag_reg;
              if (!rd_flag_reg) begin
                wdata_next = rx_shift;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (cs_rise) begin
            state_next = S_IDLE;
            miso_next  = 1'b0;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign spi_miso      = miso_reg;
  assign bus.bus_addr  = bus_addr_reg;
  assign bus.bus_wdata = wdata_reg;
  assign bus.wr_stb    = wr_stb_reg;
  assign bus.rd_stb    = rd_stb_reg;
  assign frame_err     = frame_err_reg;
  assign rd_err        = rd_err_reg;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: a host driving SPI frames, a register-file
// responder on the bus, and a table plus random frames checked against a model.
module tb_spi_reg_bridge;

  localparam int HP = 8;  // SCK half period in sys_clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sys_rst_n, spi_clk, spi_mosi, spi_cs_n, spi_miso, frame_err, rd_err;

  spi_reg_bridge_if #(.ADDR_W(8), .DATA_W(16)) bus_if ();

  spi_reg_bridge #(
    .ADDR_W(8), .DATA_W(16), .DUMMY_CYCLES(8), .SYNC_STAGES(2)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (sys_rst_n),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_miso  (spi_miso),
    .bus       (bus_if),
    .frame_err (frame_err),
    .rd_err    (rd_err)
  );

  typedef struct {
    bit        is_rd;
    bit [6:0]  addr;
    bit [15:0] data;
    int        ack_dly;   // -1: register file never acknowledges
    int        nbits;     // SCK cycles before CS is released (32 = full frame)
    int        extra;     // extra SCK cycles after the 32nd bit
    int        rst_at;    // bit index after which reset is pulsed, -1 none
    bit [15:0] exp_rd;
    int        exp_wr;
    int        exp_rstb;
    int        exp_ferr;
    int        exp_rerr;
    bit        chk_rd;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int        wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0, rerr_cnt = 0;
  logic [6:0]  wr_addr_last, rd_addr_last;
  logic [15:0] wr_data_last;
  bit [15:0] mem [128];
  bit [15:0] exp_mem [128];
  int        cur_ack_dly = -1;
  logic [6:0] resp_addr;

  // Bus monitor and downstream register-file storage.
  always @(negedge clk) begin
    if (bus_if.wr_stb === 1'b1) begin
      wr_cnt       <= wr_cnt + 1;
      wr_addr_last <= bus_if.bus_addr;
      wr_data_last <= bus_if.bus_wdata;
      mem[bus_if.bus_addr] <= bus_if.bus_wdata;
    end
    if (bus_if.rd_stb === 1'b1) begin
      rd_cnt       <= rd_cnt + 1;
      rd_addr_last <= bus_if.bus_addr;
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (rd_err === 1'b1)    rerr_cnt <= rerr_cnt + 1;
  end

  // Register-file read responder with a programmable acknowledge delay.
  initial begin
    bus_if.rd_ack  = 1'b0;
    bus_if.rd_data = '0;
    forever begin
      @(negedge clk);
      if (bus_if.rd_stb === 1'b1 && cur_ack_dly >= 0) begin
        resp_addr = bus_if.bus_addr;
        repeat (cur_ack_dly) @(negedge clk);
        bus_if.rd_ack  = 1'b1;
        bus_if.rd_data = mem[resp_addr];
        @(negedge clk);
        bus_if.rd_ack  = 1'b0;
        bus_if.rd_data = '0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Host side of one frame; MISO sampled just before each SCK rise.
  task automatic spi_frame(input logic [7:0] a, input logic [15:0] d, input int nbits,
                           input int extra, input int rst_at,
                           output logic [15:0] rd, output logic pre_nz, output logic rz);
    logic [31:0] stream;
    stream = {a, 8'($urandom), d};
    rd = '0; pre_nz = 1'b0; rz = 1'b1;
    @(negedge clk);
    spi_cs_n = 1'b0;
    spi_mosi = stream[31];
    repeat (HP) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i >= 16) rd = {rd[14:0], spi_miso};
      else if (spi_miso !== 1'b0) pre_nz = 1'b1;
      spi_clk = 1'b1;
      repeat (HP) @(negedge clk);
      spi_clk = 1'b0;
      if (i < 31) spi_mosi = stream[30-i];
      if (i == rst_at) begin
        sys_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rz = (spi_miso === 1'b0) && (bus_if.wr_stb === 1'b0) && (bus_if.rd_stb === 1'b0) &&
             (frame_err === 1'b0) && (rd_err === 1'b0) && (bus_if.bus_addr === 7'h00) &&
             (bus_if.bus_wdata === 16'h0000);
        sys_rst_n = 1'b1;
      end
      repeat (HP) @(negedge clk);
    end
    for (int i = 0; i < extra; i++) begin
      spi_clk = 1'b1;
      repeat (HP) @(negedge clk);
      spi_clk = 1'b0;
      repeat (HP) @(negedge clk);
    end
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [15:0] rd;
    logic        pre_nz, rz;
    int          w0, r0, f0, e0;
    w0 = wr_cnt; r0 = rd_cnt; f0 = ferr_cnt; e0 = rerr_cnt;
    cur_ack_dly = v.ack_dly;
    spi_frame({v.is_rd, v.addr}, v.data, v.nbits, v.extra, v.rst_at, rd, pre_nz, rz);
    $display("txn %0d %s addr=%02h wdata=%04h ack_dly=%0d nbits=%0d rst_at=%0d miso_word=%04h",
             idx, v.is_rd ? "RD" : "WR", v.addr, v.data, v.ack_dly, v.nbits, v.rst_at, rd);
    chk("wr_stb count", 32'(wr_cnt - w0), 32'(v.exp_wr));
    chk("rd_stb count", 32'(rd_cnt - r0), 32'(v.exp_rstb));
    chk("frame_err count", 32'(ferr_cnt - f0), 32'(v.exp_ferr));
    chk("rd_err count", 32'(rerr_cnt - e0), 32'(v.exp_rerr));
    chk("miso before data", 32'(pre_nz), 32'(0));
    if (v.exp_wr > 0) begin
      chk("wr bus_addr", 32'(wr_addr_last), 32'(v.addr));
      chk("wr bus_wdata", 32'(wr_data_last), 32'(v.data));
    end
    if (v.exp_rstb > 0) chk("rd bus_addr", 32'(rd_addr_last), 32'(v.addr));
    if (v.chk_rd) chk("miso word", 32'(rd), 32'(v.exp_rd));
    if (v.rst_at >= 0) chk("outputs zero in reset", 32'(rz), 32'(1));
    if (!v.is_rd && v.nbits == 32 && v.rst_at < 0) exp_mem[v.addr] = v.data;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    tbl.push_back(vec_t'{1'b0, 7'h00, 16'hAAAA, -1,  32, 0, -1, 16'h0000, 1, 0, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 7'h00, 16'h5555, -1,  32, 0, -1, 16'h0000, 1, 0, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 7'h00, 16'h0000,  3,  32, 0, -1, 16'h5555, 0, 1, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 7'h10, 16'h0000, -1,  32, 0, -1, 16'h0000, 1, 0, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 7'h10, 16'h0000,  3,  32, 0, -1, 16'h0000, 0, 1, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 7'h11, 16'h0001, -1,  32, 0, -1, 16'h0000, 1, 0, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 7'h11, 16'h0000,  3,  32, 0, -1, 16'h0001, 0, 1, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 7'h12, 16'h8000, -1,  32, 0, -1, 16'h0000, 1, 0, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 7'h12, 16'h0000,  3,  32, 0, -1, 16'h8000, 0, 1, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 7'h13, 16'hFFFF, -1,  32, 0, -1, 16'h0000, 1, 0, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 7'h13, 16'h0000,  3,  32, 0, -1, 16'hFFFF, 0, 1, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 7'h14, 16'h2A2A, -1,  32, 0, -1, 16'h0000, 1, 0, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 7'h14, 16'h0000,  3,  32, 0, -1, 16'h2A2A, 0, 1, 0, 0, 1'b1});
    // timeout: no ack, and an ack arriving after the turnaround
    tbl.push_back(vec_t'{1'b1, 7'h0F, 16'h0000, -1,  32, 0, -1, 16'h0000, 0, 1, 0, 1, 1'b1});
    tbl.push_back(vec_t'{1'b1, 7'h13, 16'h0000, 200, 32, 0, -1, 16'h0000, 0, 1, 0, 1, 1'b1});
    // abort after 10 data bits, then a normal write
    tbl.push_back(vec_t'{1'b0, 7'h05, 16'hBEEF, -1,  26, 0, -1, 16'h0000, 0, 0, 1, 0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 7'h03, 16'h1234, -1,  32, 0, -1, 16'h0000, 1, 0, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 7'h03, 16'h0000,  2,  32, 0, -1, 16'h1234, 0, 1, 0, 0, 1'b1});
    // reset in the middle of the data phase, then normal operation
    tbl.push_back(vec_t'{1'b0, 7'h06, 16'hC3C3, -1,  32, 0, 20, 16'h0000, 0, 0, 0, 0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 7'h06, 16'h0F0F, -1,  32, 0, -1, 16'h0000, 1, 0, 0, 0, 1'b1});
    // extra SCK after the 32nd bit
    tbl.push_back(vec_t'{1'b0, 7'h07, 16'h1357, -1,  32, 4, -1, 16'h0000, 1, 0, 0, 0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 7'h06, 16'h0000,  5,  32, 0, -1, 16'h0F0F, 0, 1, 0, 0, 1'b1});
    // read aborted mid-data, then a zero-latency ack
    tbl.push_back(vec_t'{1'b1, 7'h03, 16'h0000,  1,  20, 0, -1, 16'h0000, 0, 1, 1, 0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 7'h07, 16'h0000,  0,  32, 0, -1, 16'h1357, 0, 1, 0, 0, 1'b1});

    sys_rst_n = 1'b0;
    spi_clk   = 1'b0;
    spi_mosi  = 1'b0;
    spi_cs_n  = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset spi_miso", 32'(spi_miso), 32'(0));
    chk("reset strobes", 32'({bus_if.wr_stb, bus_if.rd_stb, frame_err, rd_err}), 32'(0));
    chk("reset bus_addr", 32'(bus_if.bus_addr), 32'(0));
    chk("reset bus_wdata", 32'(bus_if.bus_wdata), 32'(0));
    sys_rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no pulses after reset", 32'(wr_cnt + rd_cnt + ferr_cnt + rerr_cnt), 32'(0));

    foreach (tbl[i]) run_vec(i, tbl[i]);

    // Random frames over a small address pool, expectations from exp_mem.
    for (int n = 0; n < 16; n++) begin
      v.is_rd    = 1'($urandom_range(0, 1));
      v.addr     = 7'($urandom_range(32, 39));
      v.data     = 16'($urandom);
      v.ack_dly  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 30));
      v.nbits    = 32;
      v.extra    = 0;
      v.rst_at   = -1;
      v.exp_wr   = v.is_rd ? 0 : 1;
      v.exp_rstb = v.is_rd ? 1 : 0;
      v.exp_ferr = 0;
      v.exp_rerr = (v.is_rd && v.ack_dly < 0) ? 1 : 0;
      v.exp_rd   = (v.is_rd && v.ack_dly >= 0) ? exp_mem[v.addr] : 16'h0000;
      v.chk_rd   = 1'b1;
      run_vec(100 + n, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
